xmss_thash_f: RTL and testbench
===============================

XMSS_THASH_F -- requirements
Module: xmss_thash_f

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: start  in  1  one-cycle request pulse; seed  in  256  public seed; adrs  in  256  32-byte ADRS, big-endian, keyAndMask word = adrs[31:0]; msg_in  in  256  n-byte message M.
REQ-003 SHALL have ports: data_out  out  256  F result; data_out_valid  out  1  result valid; done  out  1  one-cycle completion pulse; busy  out  1  operation in progress.
REQ-004 SHALL have hash-core ports: hash_start  out  1; hash_init_iv  out  1; hash_data_in  out  1024; hash_message_length  out  1; hash_store_intermediate  out  1; hash_continue_intermediate  out  1; hash_second_block_data_available  out  1; hash_data_out  in  256; hash_done  in  1.
REQ-005 SHALL tie hash_init_iv=0, hash_message_length=0 (768-bit), hash_store_intermediate=0, hash_continue_intermediate=0, hash_second_block_data_available=1.

Function
REQ-006 SHALL compute XMSS F: KEY=PRF(seed, adrs with keyAndMask=0), BM=PRF(seed, adrs with keyAndMask=1), result=SHA256(toByte(0,32)||KEY||(M xor BM)).
REQ-007 SHALL latch seed, adrs and msg_in on the cycle start is accepted; later input changes SHALL NOT affect the operation.
REQ-008 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored, with no state change.
REQ-009 FSM states: IDLE, PRF_KEY, PRF_MASK, F_HASH, FIN; transitions: IDLE-(start)->PRF_KEY-(hash_done)->PRF_MASK-(hash_done)->F_HASH-(hash_done)->FIN->IDLE.
REQ-010 SHALL pulse hash_start for exactly one cycle, the first cycle of each of PRF_KEY, PRF_MASK and F_HASH.
REQ-011 hash_data_in in PRF_KEY SHALL be {256'd3, seed, adrs[255:32], 32'd0, 256'd0}; in PRF_MASK {256'd3, seed, adrs[255:32], 32'd1, 256'd0}; in F_HASH {256'd0, KEY, msg xor BM, 256'd0}.
REQ-012 hash_data_in SHALL be registered and stable from its hash_start cycle through the matching hash_done cycle.
REQ-013 SHALL capture hash_data_out into KEY on hash_done in PRF_KEY, into BM on hash_done in PRF_MASK, and into data_out on hash_done in F_HASH.
REQ-014 hash_done in IDLE or FIN SHALL be ignored.
REQ-015 Timing, with start sampled at cycle 0: first hash_start at cycle 1; each subsequent hash_start 1 cycle after the preceding hash_done; done 1 cycle after the F_HASH hash_done (the FIN cycle).
REQ-016 busy SHALL be 1 from the cycle after start is accepted until the cycle done is 1, inclusive, and 0 otherwise.
REQ-017 data_out_valid SHALL rise together with done and stay 1 until the next accepted start, at which point it SHALL fall and data_out SHALL hold its old value until overwritten.
REQ-018 A start in the FIN cycle SHALL be ignored; a start in the cycle after FIN SHALL be accepted.

Reset
REQ-019 Reset SHALL set: state=IDLE, data_out=0, data_out_valid=0, done=0, busy=0, hash_start=0, hash_data_in=0, KEY=0, BM=0.
REQ-020 Reset mid-operation SHALL abort immediately with no done pulse; hash_start SHALL be 0 in the cycle after reset deasserts.
REQ-021 reset SHALL take priority over start and hash_done asserted in the same cycle.

Verification
REQ-022 Bench uses a mock core with latency L=10 that returns 0xAA..AA, 0x55..55, 0x1234..(fixed) in sequence.
REQ-023 Scenario: seed=0, adrs=0xFF..FF, msg=0 -> PRF_KEY data_in={3, 0, 0xFF..FF00000000, 0}; PRF_MASK word=1; F data_in={0, 0xAA..AA, 0x55..55, 0}; done at cycle 34; data_out=0x1234...
REQ-024 Scenario: msg=0xFF..FF with the same mock -> F data_in third word=0xAA..AA (msg xor BM).
REQ-025 Scenario: start pulsed at cycles 5 and 20 during operation -> ignored; exactly three hash_start pulses; one done pulse.
REQ-026 Scenario: reset asserted at cycle 15 -> busy=0, data_out_valid=0, no done; a new start at cycle 20 completes normally with done at cycle 54.
REQ-027 Scenario: back-to-back ops (start in FIN ignored, start at FIN+1 accepted) -> data_out_valid drops the cycle after the second start; the old data_out is held until the new done.
REQ-028 Scenario: spurious hash_done in IDLE, and inputs changed mid-operation -> no state change; result matches the latched inputs.

Source files
------------

// File: rtl/xmss_thash_f_if.sv
// ---------------------------------------------------------------------------
// xmss_thash_f_if
//
// Bus between the XMSS F engine and an external SHA-256 compression core.
// The engine owns the request side (start pulse, block data and the mode
// flags); the core answers with a digest and a one-cycle done strobe.
//
// Signals:
//   hash_start                         engine -> core, one-cycle request pulse
//   hash_init_iv                       engine -> core, mode flag
//   hash_data_in[1023:0]               engine -> core, 1024-bit message data
//   hash_message_length                engine -> core, 0 selects 768-bit message
//   hash_store_intermediate            engine -> core, mode flag
//   hash_continue_intermediate         engine -> core, mode flag
//   hash_second_block_data_available   engine -> core, mode flag
//   hash_data_out[255:0]               core -> engine, digest
//   hash_done                          core -> engine, digest valid pulse
//
// Modports:
//   master  the F engine (drives requests)
//   slave   the hash core (drives results)
// ---------------------------------------------------------------------------
interface xmss_thash_f_if;
    logic          hash_start;
    logic          hash_init_iv;
    logic [1023:0] hash_data_in;
    logic          hash_message_length;
    logic          hash_store_intermediate;
    logic          hash_continue_intermediate;
    logic          hash_second_block_data_available;
    logic [255:0]  hash_data_out;
    logic          hash_done;

    modport master (
        output hash_start,
        output hash_init_iv,
        output hash_data_in,
        output hash_message_length,
        output hash_store_intermediate,
        output hash_continue_intermediate,
        output hash_second_block_data_available,
        input  hash_data_out,
        input  hash_done
    );

    modport slave (
        input  hash_start,
        input  hash_init_iv,
        input  hash_data_in,
        input  hash_message_length,
        input  hash_store_intermediate,
        input  hash_continue_intermediate,
        input  hash_second_block_data_available,
        output hash_data_out,
        output hash_done
    );
endinterface

// File: rtl/xmss_thash_f.sv
// ---------------------------------------------------------------------------
// xmss_thash_f
//
// XMSS tweakable hash F built around an external SHA-256 core:
//   KEY    = PRF(seed, adrs with keyAndMask = 0)
//   BM     = PRF(seed, adrs with keyAndMask = 1)
//   result = SHA256(toByte(0,32) || KEY || (M xor BM))
// Each PRF and the final hash is one 768-bit message sent to the core as a
// 1024-bit data word whose low 256 bits are zero.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   start           one-cycle request pulse, accepted only when idle
//   seed[255:0]     public seed
//   adrs[255:0]     32-byte ADRS, big-endian; keyAndMask word is adrs[31:0]
//   msg_in[255:0]   n-byte message M
//   data_out[255:0] F result, held until the next result overwrites it
//   data_out_valid  result valid; cleared when a new start is accepted
//   done            one-cycle completion pulse
//   busy            operation in progress
//   hash            master side of the hash-core bus
// ---------------------------------------------------------------------------
module xmss_thash_f (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [255:0]   seed,
    input  logic [255:0]   adrs,
    input  logic [255:0]   msg_in,
    output logic [255:0]   data_out,
    output logic           data_out_valid,
    output logic           done,
    output logic           busy,
    xmss_thash_f_if.master hash
);

    typedef enum logic [2:0] {
        IDLE,
        PRF_KEY,
        PRF_MASK,
        F_HASH,
        FIN
    } state_t;

    state_t         state;
    state_t         next_state;

    // Operands latched at the accepted start; the keyAndMask word of adrs
    // is always replaced, so only the upper 224 bits are kept.
    logic [255:0]   seed_q;
    logic [223:0]   adrs_hi_q;
    logic [255:0]   msg_q;
    logic [255:0]   key_q;
    logic [255:0]   bm_q;

    logic           accept;
    logic           issue;
    logic [1023:0]  next_block;
    logic [255:0]   bm_cur;

    // The core runs in single 768-bit-message mode for every request.
    assign hash.hash_init_iv                     = 1'b0;
    assign hash.hash_message_length              = 1'b0;
    assign hash.hash_store_intermediate          = 1'b0;
    assign hash.hash_continue_intermediate       = 1'b0;
    assign hash.hash_second_block_data_available = 1'b1;

    // The F block is built on the same edge that BM arrives, so BM is
    // taken straight from the core on that cycle instead of from bm_q.
    assign bm_cur = (state == PRF_MASK && hash.hash_done) ? hash.hash_data_out : bm_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, status outputs and the block to send on each new request.
    // The first PRF block uses the live inputs because the operand
    // registers only load on the same edge.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        issue      = 1'b0;
        next_block = '0;
        busy       = (state != IDLE);
        done       = (state == FIN);
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = PRF_KEY;
                    accept     = 1'b1;
                    issue      = 1'b1;
                    next_block = {256'd3, seed, adrs[255:32], 32'd0, 256'd0};
                end
            end
            PRF_KEY: begin
                if (hash.hash_done) begin
                    next_state = PRF_MASK;
                    issue      = 1'b1;
                    next_block = {256'd3, seed_q, adrs_hi_q, 32'd1, 256'd0};
                end
            end
            PRF_MASK: begin
                if (hash.hash_done) begin
                    next_state = F_HASH;
                    issue      = 1'b1;
                    next_block = {256'd0, key_q, msg_q ^ bm_cur, 256'd0};
                end
            end
            F_HASH: begin
                if (hash.hash_done) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: request pulse and block register, operand latches, and the
    // capture of each digest into KEY, BM or the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hash.hash_start   <= 1'b0;
            hash.hash_data_in <= '0;
            seed_q            <= '0;
            adrs_hi_q         <= '0;
            msg_q             <= '0;
            key_q             <= '0;
            bm_q              <= '0;
            data_out          <= '0;
            data_out_valid    <= 1'b0;
        end else begin
            hash.hash_start <= issue;
            if (issue) begin
                hash.hash_data_in <= next_block;
            end
            if (accept) begin
                seed_q         <= seed;
                adrs_hi_q      <= adrs[255:32];
                msg_q          <= msg_in;
                data_out_valid <= 1'b0;
            end
            if (state == PRF_KEY && hash.hash_done) begin
                key_q <= hash.hash_data_out;
            end
            if (state == PRF_MASK && hash.hash_done) begin
                bm_q <= hash.hash_data_out;
            end
            if (state == F_HASH && hash.hash_done) begin
                data_out       <= hash.hash_data_out;
                data_out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xmss_thash_f.sv
// ---------------------------------------------------------------------------
// tb_xmss_thash_f
//
// Bench for xmss_thash_f with a mock hash core of latency 10 that answers
// with a fixed sequence (KEY, BM, F result). Expected hash blocks, results
// and done cycles are queued when a start is driven and consumed by a
// negedge monitor as the design produces them.
// ---------------------------------------------------------------------------
module tb_xmss_thash_f;

    localparam logic [255:0] RESP_KEY = {32{8'hAA}};
    localparam logic [255:0] RESP_BM  = {32{8'h55}};
    localparam logic [255:0] RESP_F   =
        256'h123456789abcdef0_0fedcba987654321_1122334455667788_99aabbccddeeff00;
    localparam int LATENCY = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] seed;
    logic [255:0] adrs;
    logic [255:0] msg_in;
    logic [255:0] data_out;
    logic         data_out_valid;
    logic         done;
    logic         busy;

    xmss_thash_f_if bus();

    logic         mock_done;
    logic         spurious_done;
    logic [255:0] mock_out;
    int           mock_cnt;
    int           mock_idx;

    int           cyc;
    int           n_checks;
    int           n_bad;
    int           n_hash_start;
    int           n_done;

    logic [1023:0] exp_blk[$];
    logic [255:0]  exp_res[$];
    int            exp_done_cyc[$];
    logic [1023:0] held_blk;

    assign bus.hash_done     = mock_done | spurious_done;
    assign bus.hash_data_out = mock_out;

    xmss_thash_f dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .seed           (seed),
        .adrs           (adrs),
        .msg_in         (msg_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .done           (done),
        .busy           (busy),
        .hash           (bus)
    );

    always #5 clk = ~clk;

    // Cycle label: a value sampled at a negedge belongs to cycle cyc.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Mock core: hash_done is seen by the design LATENCY edges after the
    // edge that sampled hash_start; responses cycle KEY, BM, F.
    always @(posedge clk) begin
        if (reset) begin
            mock_cnt  <= 0;
            mock_idx  <= 0;
            mock_done <= 1'b0;
            mock_out  <= '0;
        end else begin
            mock_done <= 1'b0;
            if (bus.hash_start) begin
                mock_cnt <= LATENCY;
            end else if (mock_cnt != 0) begin
                mock_cnt <= mock_cnt - 1;
                if (mock_cnt == 2) begin
                    mock_done <= 1'b1;
                    mock_out  <= (mock_idx == 0) ? RESP_KEY :
                                 (mock_idx == 1) ? RESP_BM  : RESP_F;
                    mock_idx  <= (mock_idx == 2) ? 0 : mock_idx + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every request and completion.
    always @(negedge clk) begin
        logic [1023:0] blk;
        if (!reset) begin
            if (bus.hash_start) begin
                n_hash_start++;
                if (exp_blk.size() == 0) begin
                    checkOutput("unexpected_hash_start", 256'd1, 256'd0);
                end else begin
                    blk = exp_blk.pop_front();
                    checkOutput("blk_w3", bus.hash_data_in[1023:768], blk[1023:768]);
                    checkOutput("blk_w2", bus.hash_data_in[767:512], blk[767:512]);
                    checkOutput("blk_w1", bus.hash_data_in[511:256], blk[511:256]);
                    checkOutput("blk_w0", bus.hash_data_in[255:0], blk[255:0]);
                end
                held_blk = bus.hash_data_in;
            end else if (bus.hash_done && busy) begin
                checkOutput("data_in_stable", 256'(bus.hash_data_in != held_blk), 256'd0);
            end
            if (done) begin
                n_done++;
                if (exp_res.size() == 0 || exp_done_cyc.size() == 0) begin
                    checkOutput("unexpected_done", 256'd1, 256'd0);
                end else begin
                    checkOutput("data_out", data_out, exp_res.pop_front());
                    checkOutput("done_cycle", 256'(cyc), 256'(exp_done_cyc.pop_front()));
                    checkOutput("valid_with_done", 256'(data_out_valid), 256'd1);
                    checkOutput("busy_with_done", 256'(busy), 256'd1);
                end
            end
        end
    end

    // Drives one accepted request and queues its expected blocks/result.
    task automatic applyStimulus(input logic [255:0] s, input logic [255:0] a, input logic [255:0] m);
        @(negedge clk);
        seed   = s;
        adrs   = a;
        msg_in = m;
        start  = 1'b1;
        exp_blk.push_back({256'd3, s, a[255:32], 32'd0, 256'd0});
        exp_blk.push_back({256'd3, s, a[255:32], 32'd1, 256'd0});
        exp_blk.push_back({256'd0, RESP_KEY, m ^ RESP_BM, 256'd0});
        exp_res.push_back(RESP_F);
        exp_done_cyc.push_back(cyc + 34);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_timeout", 256'(done), 256'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] watchdog expired");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hs0;
        int dn0;
        logic [255:0] ones;
        ones          = '1;
        cyc           = 0;
        n_checks      = 0;
        n_bad         = 0;
        n_hash_start  = 0;
        n_done        = 0;
        held_blk      = '0;
        reset         = 1'b1;
        start         = 1'b0;
        seed          = '0;
        adrs          = '0;
        msg_in        = '0;
        spurious_done = 1'b0;

        // Reset state, with start and hash_done both asserted under reset.
        repeat (2) @(negedge clk);
        start         = 1'b1;
        spurious_done = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        spurious_done = 1'b0;
        checkOutput("rst_busy", 256'(busy), 256'd0);
        checkOutput("rst_done", 256'(done), 256'd0);
        checkOutput("rst_valid", 256'(data_out_valid), 256'd0);
        checkOutput("rst_data_out", data_out, 256'd0);
        checkOutput("rst_hash_start", 256'(bus.hash_start), 256'd0);
        checkOutput("rst_hash_data_in", 256'(bus.hash_data_in != 1024'd0), 256'd0);
        checkOutput("tie_flags", 256'({bus.hash_init_iv, bus.hash_message_length,
            bus.hash_store_intermediate, bus.hash_continue_intermediate,
            bus.hash_second_block_data_available}), 256'd1);
        reset = 1'b0;
        @(negedge clk);

        // Basic operation: seed 0, adrs all ones, msg 0.
        applyStimulus('0, ones, '0);
        waitDone(100);
        @(negedge clk);
        checkOutput("idle_busy", 256'(busy), 256'd0);
        checkOutput("valid_held", 256'(data_out_valid), 256'd1);

        // msg all ones: masked message becomes 0xAA..AA.
        applyStimulus({8{32'hdeadbeef}}, {8{32'h01234567}}, ones);
        waitDone(100);
        @(negedge clk);

        // Starts during an operation are ignored; input changes do not leak.
        hs0 = n_hash_start;
        dn0 = n_done;
        applyStimulus({4{64'h0f1e2d3c4b5a6978}}, {16{16'hc3a5}}, {2{128'h0123456789abcdeffedcba9876543210}});
        repeat (4) @(negedge clk);
        seed   = ones;
        adrs   = '0;
        msg_in = {32{8'h5a}};
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (14) @(negedge clk);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waitDone(100);
        @(negedge clk);
        checkOutput("three_hash_starts", 256'(n_hash_start - hs0), 256'd3);
        checkOutput("one_done", 256'(n_done - dn0), 256'd1);

        // Reset at cycle 15 aborts; new start at cycle 20 completes at 54.
        dn0 = n_done;
        applyStimulus({8{32'h11111111}}, {8{32'h22222222}}, {8{32'h33333333}});
        repeat (14) @(negedge clk);
        reset = 1'b1;
        exp_blk.delete();
        exp_res.delete();
        exp_done_cyc.delete();
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 256'(busy), 256'd0);
        checkOutput("abort_valid", 256'(data_out_valid), 256'd0);
        checkOutput("abort_data_out", data_out, 256'd0);
        @(negedge clk);
        checkOutput("post_reset_hash_start", 256'(bus.hash_start), 256'd0);
        repeat (2) @(negedge clk);
        checkOutput("abort_no_done", 256'(n_done - dn0), 256'd0);
        applyStimulus({8{32'h44444444}}, {8{32'h55555555}}, {8{32'h66666666}});
        waitDone(100);

        // Back to back: start held over FIN (ignored) and FIN+1 (accepted).
        seed   = {8{32'h77777777}};
        adrs   = {8{32'h88888888}};
        msg_in = {8{32'h99999999}};
        start  = 1'b1;
        @(negedge clk);
        checkOutput("fin_start_ignored", 256'(bus.hash_start), 256'd0);
        checkOutput("b2b_valid_before", 256'(data_out_valid), 256'd1);
        checkOutput("b2b_busy_before", 256'(busy), 256'd0);
        exp_blk.push_back({256'd3, seed, adrs[255:32], 32'd0, 256'd0});
        exp_blk.push_back({256'd3, seed, adrs[255:32], 32'd1, 256'd0});
        exp_blk.push_back({256'd0, RESP_KEY, msg_in ^ RESP_BM, 256'd0});
        exp_res.push_back(RESP_F);
        exp_done_cyc.push_back(cyc + 34);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_valid_dropped", 256'(data_out_valid), 256'd0);
        checkOutput("b2b_data_held", data_out, RESP_F);
        checkOutput("b2b_busy", 256'(busy), 256'd1);
        repeat (15) @(negedge clk);
        checkOutput("b2b_data_held_mid", data_out, RESP_F);
        waitDone(100);
        repeat (2) @(negedge clk);

        // Spurious hash_done in IDLE changes nothing.
        spurious_done = 1'b1;
        @(negedge clk);
        spurious_done = 1'b0;
        @(negedge clk);
        checkOutput("spurious_busy", 256'(busy), 256'd0);
        checkOutput("spurious_valid", 256'(data_out_valid), 256'd1);
        checkOutput("spurious_data_out", data_out, RESP_F);

        // Inputs changed mid-operation; result follows the latched values.
        applyStimulus({8{32'hcafef00d}}, {8{32'hfeedface}}, {8{32'h0badc0de}});
        repeat (3) @(negedge clk);
        seed   = '0;
        adrs   = ones;
        msg_in = ones;
        repeat (12) @(negedge clk);
        seed   = {8{32'h13579bdf}};
        msg_in = '0;
        waitDone(100);
        repeat (3) @(negedge clk);

        checkOutput("leftover_blocks", 256'(exp_blk.size()), 256'd0);
        checkOutput("leftover_results", 256'(exp_res.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
